// File: rtl/wb_dual_master_arbiter.sv
// -----------------------------------------------------------------------------
// wb_dual_master_arbiter
//
// Two-master, one-slave Wishbone arbiter. Master 0 is instruction fetch and
// master 1 is data memory. The owner's request is passed combinationally to
// the slave. The slave ack goes only to the owner. A watchdog can abort a
// stalled transfer.
//
// Configuration macro:
//   WB_ARB_ROUND_ROBIN_EN  defined   : simultaneous requests alternate
//                                      (the master that did not win last wins)
//                          undefined : fixed priority, master 1 wins
//
// Parameters:
//   ADDR_WIDTH  Wishbone address width
//   DATA_WIDTH  Wishbone data width (select width = DATA_WIDTH/8)
//   TIMEOUT     stalled owned cycles before abort; 0 disables the watchdog
//
// Ports:
//   clk, reset                 clock, synchronous active-high reset
//   m0_wb_* / m1_wb_*          master request inputs, ack/data responses
//   s_wb_*                     shared slave request outputs, ack/data inputs
//   grant_o                    one-hot owner {m1,m0}, 00 when idle
//   timeout_o                  sticky watchdog-expiry flag
// -----------------------------------------------------------------------------
module wb_dual_master_arbiter #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int TIMEOUT    = 255
) (
  input  logic                    clk,
  input  logic                    reset,
  // master 0 (instruction fetch)
  input  logic                    m0_wb_cyc_i,
  input  logic                    m0_wb_stb_i,
  input  logic                    m0_wb_we_i,
  input  logic [ADDR_WIDTH-1:0]   m0_wb_adr_i,
  input  logic [DATA_WIDTH-1:0]   m0_wb_dat_i,
  input  logic [DATA_WIDTH/8-1:0] m0_wb_sel_i,
  output logic                    m0_wb_ack_o,
  output logic [DATA_WIDTH-1:0]   m0_wb_dat_o,
  // master 1 (data memory)
  input  logic                    m1_wb_cyc_i,
  input  logic                    m1_wb_stb_i,
  input  logic                    m1_wb_we_i,
  input  logic [ADDR_WIDTH-1:0]   m1_wb_adr_i,
  input  logic [DATA_WIDTH-1:0]   m1_wb_dat_i,
  input  logic [DATA_WIDTH/8-1:0] m1_wb_sel_i,
  output logic                    m1_wb_ack_o,
  output logic [DATA_WIDTH-1:0]   m1_wb_dat_o,
  // shared slave
  output logic                    s_wb_cyc_o,
  output logic                    s_wb_stb_o,
  output logic                    s_wb_we_o,
  output logic [ADDR_WIDTH-1:0]   s_wb_adr_o,
  output logic [DATA_WIDTH-1:0]   s_wb_dat_o,
  output logic [DATA_WIDTH/8-1:0] s_wb_sel_o,
  input  logic                    s_wb_ack_i,
  input  logic [DATA_WIDTH-1:0]   s_wb_dat_i,
  // status
  output logic [1:0]              grant_o,
  output logic                    timeout_o
);

  // The counter is wide enough to hold TIMEOUT itself, so it never wraps.
  localparam int CNT_WIDTH = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam bit WD_EN     = (TIMEOUT > 0);
  // Expiry fires on the stalled cycle that would bring the count to TIMEOUT.
  localparam logic [CNT_WIDTH-1:0] CNT_LAST =
    CNT_WIDTH'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    GNT_M0 = 2'd1,
    GNT_M1 = 2'd2
  } state_t;

  state_t                 state_q, state_d;
  logic [1:0]             grant_q, grant_d;
  logic [CNT_WIDTH-1:0]   cnt_q, cnt_d;
  logic                   timeout_q, timeout_d;
  logic                   req0, req1;
  logic                   own_cyc, own_stb;
`ifdef WB_ARB_ROUND_ROBIN_EN
  logic                   last_m1_q, last_m1_d;
`endif

  assign req0    = m0_wb_cyc_i & m0_wb_stb_i;
  assign req1    = m1_wb_cyc_i & m1_wb_stb_i;
  assign own_cyc = (state_q == GNT_M1) ? m1_wb_cyc_i : m0_wb_cyc_i;
  assign own_stb = (state_q == GNT_M1) ? m1_wb_stb_i : m0_wb_stb_i;

  // Next-state / watchdog logic.
  // NOTE: every variable gets a default at the top so no path infers a latch.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    timeout_d = timeout_q;
`ifdef WB_ARB_ROUND_ROBIN_EN
    last_m1_d = last_m1_q;
`endif
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (req0 && req1) begin
`ifdef WB_ARB_ROUND_ROBIN_EN
          state_d = last_m1_q ? GNT_M0 : GNT_M1;
`else
          state_d = GNT_M1;
`endif
        end else if (req1) begin
          state_d = GNT_M1;
        end else if (req0) begin
          state_d = GNT_M0;
        end
`ifdef WB_ARB_ROUND_ROBIN_EN
        if (state_d != IDLE) last_m1_d = (state_d == GNT_M1);
`endif
      end
      GNT_M0, GNT_M1: begin
        if (!own_cyc) begin
          // Owner released the bus; a coincident ack was already routed.
          state_d = IDLE;
          cnt_d   = '0;
        end else if (s_wb_ack_i) begin
          cnt_d = '0;
        end else if (WD_EN && own_stb) begin
          if (cnt_q == CNT_LAST) begin
            state_d   = IDLE;
            cnt_d     = '0;
            timeout_d = 1'b1;
          end else begin
            cnt_d = cnt_q + CNT_WIDTH'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase

    case (state_d)
      GNT_M0:  grant_d = 2'b01;
      GNT_M1:  grant_d = 2'b10;
      default: grant_d = 2'b00;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      grant_q   <= 2'b00;
      cnt_q     <= '0;
      timeout_q <= 1'b0;
`ifdef WB_ARB_ROUND_ROBIN_EN
      last_m1_q <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      grant_q   <= grant_d;
      cnt_q     <= cnt_d;
      timeout_q <= timeout_d;
`ifdef WB_ARB_ROUND_ROBIN_EN
      last_m1_q <= last_m1_d;
`endif
    end
  end

  // Request mux and ack routing. Reset gates these combinationally so the
  // slave sees no request during the cycle reset is being sampled.
  always_comb begin
    s_wb_cyc_o  = 1'b0;
    s_wb_stb_o  = 1'b0;
    s_wb_we_o   = 1'b0;
    s_wb_adr_o  = '0;
    s_wb_dat_o  = '0;
    s_wb_sel_o  = '0;
    m0_wb_ack_o = 1'b0;
    m1_wb_ack_o = 1'b0;
    if (!reset) begin
      case (state_q)
        GNT_M0: begin
          s_wb_cyc_o  = m0_wb_cyc_i;
          s_wb_stb_o  = m0_wb_stb_i;
          s_wb_we_o   = m0_wb_we_i;
          s_wb_adr_o  = m0_wb_adr_i;
          s_wb_dat_o  = m0_wb_dat_i;
          s_wb_sel_o  = m0_wb_sel_i;
          m0_wb_ack_o = s_wb_ack_i;
        end
        GNT_M1: begin
          s_wb_cyc_o  = m1_wb_cyc_i;
          s_wb_stb_o  = m1_wb_stb_i;
          s_wb_we_o   = m1_wb_we_i;
          s_wb_adr_o  = m1_wb_adr_i;
          s_wb_dat_o  = m1_wb_dat_i;
          s_wb_sel_o  = m1_wb_sel_i;
          m1_wb_ack_o = s_wb_ack_i;
        end
        default: ;
      endcase
    end
  end

  // Read data fans out to both masters; only the ack qualifies it.
  assign m0_wb_dat_o = s_wb_dat_i;
  assign m1_wb_dat_o = s_wb_dat_i;
  assign grant_o     = grant_q;
  assign timeout_o   = timeout_q;

endmodule

// File: tb/tb_wb_dual_master_arbiter.sv
// -----------------------------------------------------------------------------
// tb_wb_dual_master_arbiter
//
// Drives both masters and the slave response, then checks every output each
// cycle against an ownership model that is kept inside this bench. Directed
// scenarios run first with literal expectations. Randomized traffic and
// occasional resets follow. A second instance with TIMEOUT=0 must never
// raise timeout_o.
// -----------------------------------------------------------------------------
module tb_wb_dual_master_arbiter;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int SW = DW / 8;
  localparam int TO = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic          m0_cyc, m0_stb, m0_we, m1_cyc, m1_stb, m1_we;
  logic [AW-1:0] m0_adr, m1_adr;
  logic [DW-1:0] m0_dat, m1_dat;
  logic [SW-1:0] m0_sel, m1_sel;
  logic          s_ack;
  logic [DW-1:0] s_dat_i;

  logic          m0_ack, m1_ack, s_cyc, s_stb, s_we, timeout;
  logic [DW-1:0] m0_dat_o, m1_dat_o, s_dat_o;
  logic [AW-1:0] s_adr;
  logic [SW-1:0] s_sel;
  logic [1:0]    grant;

  logic          m0_ack_z, m1_ack_z, s_cyc_z, s_stb_z, s_we_z, timeout_z;
  logic [DW-1:0] m0_dat_o_z, m1_dat_o_z, s_dat_o_z;
  logic [AW-1:0] s_adr_z;
  logic [SW-1:0] s_sel_z;
  logic [1:0]    grant_z;

  wb_dual_master_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT(TO)) u_dut (
    .clk(clk), .reset(reset),
    .m0_wb_cyc_i(m0_cyc), .m0_wb_stb_i(m0_stb), .m0_wb_we_i(m0_we),
    .m0_wb_adr_i(m0_adr), .m0_wb_dat_i(m0_dat), .m0_wb_sel_i(m0_sel),
    .m0_wb_ack_o(m0_ack), .m0_wb_dat_o(m0_dat_o),
    .m1_wb_cyc_i(m1_cyc), .m1_wb_stb_i(m1_stb), .m1_wb_we_i(m1_we),
    .m1_wb_adr_i(m1_adr), .m1_wb_dat_i(m1_dat), .m1_wb_sel_i(m1_sel),
    .m1_wb_ack_o(m1_ack), .m1_wb_dat_o(m1_dat_o),
    .s_wb_cyc_o(s_cyc), .s_wb_stb_o(s_stb), .s_wb_we_o(s_we),
    .s_wb_adr_o(s_adr), .s_wb_dat_o(s_dat_o), .s_wb_sel_o(s_sel),
    .s_wb_ack_i(s_ack), .s_wb_dat_i(s_dat_i),
    .grant_o(grant), .timeout_o(timeout)
  );

  wb_dual_master_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT(0)) u_dut_nowd (
    .clk(clk), .reset(reset),
    .m0_wb_cyc_i(m0_cyc), .m0_wb_stb_i(m0_stb), .m0_wb_we_i(m0_we),
    .m0_wb_adr_i(m0_adr), .m0_wb_dat_i(m0_dat), .m0_wb_sel_i(m0_sel),
    .m0_wb_ack_o(m0_ack_z), .m0_wb_dat_o(m0_dat_o_z),
    .m1_wb_cyc_i(m1_cyc), .m1_wb_stb_i(m1_stb), .m1_wb_we_i(m1_we),
    .m1_wb_adr_i(m1_adr), .m1_wb_dat_i(m1_dat), .m1_wb_sel_i(m1_sel),
    .m1_wb_ack_o(m1_ack_z), .m1_wb_dat_o(m1_dat_o_z),
    .s_wb_cyc_o(s_cyc_z), .s_wb_stb_o(s_stb_z), .s_wb_we_o(s_we_z),
    .s_wb_adr_o(s_adr_z), .s_wb_dat_o(s_dat_o_z), .s_wb_sel_o(s_sel_z),
    .s_wb_ack_i(s_ack), .s_wb_dat_i(s_dat_i),
    .grant_o(grant_z), .timeout_o(timeout_z)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Reference model: who owns the bus (0 none, 1 m0, 2 m1), how many stalled
  // owned cycles have passed, the sticky timeout flag and the last winner.
  // Evaluated on the falling edge: first the current outputs are checked,
  // then the ownership after the coming rising edge is computed. Inputs only
  // change just after rising edges, so they are stable across that window.
  // ---------------------------------------------------------------------------
  int            mdl_owner   = 0;
  int            mdl_stalls  = 0;
  bit            mdl_timeout = 1'b0;
  bit            mdl_last_m1 = 1'b0;
  bit            mdl_valid   = 1'b0;
  bit            live0, live1, own_cyc, own_stb, want_m1;
  logic [1:0]    exp_grant;

  always @(negedge clk) begin
    if (mdl_valid) begin
      live0     = (mdl_owner == 1) && !reset;
      live1     = (mdl_owner == 2) && !reset;
      exp_grant = (mdl_owner == 1) ? 2'b01 : (mdl_owner == 2) ? 2'b10 : 2'b00;
      check("grant",    grant,   exp_grant);
      check("s_cyc",    s_cyc,   live0 ? m0_cyc : live1 ? m1_cyc : 1'b0);
      check("s_stb",    s_stb,   live0 ? m0_stb : live1 ? m1_stb : 1'b0);
      check("s_we",     s_we,    live0 ? m0_we  : live1 ? m1_we  : 1'b0);
      check("s_adr",    s_adr,   live0 ? m0_adr : live1 ? m1_adr : '0);
      check("s_dat",    s_dat_o, live0 ? m0_dat : live1 ? m1_dat : '0);
      check("s_sel",    s_sel,   live0 ? m0_sel : live1 ? m1_sel : '0);
      check("m0_ack",   m0_ack,  live0 && s_ack);
      check("m1_ack",   m1_ack,  live1 && s_ack);
      check("m0_rdata", m0_dat_o, s_dat_i);
      check("m1_rdata", m1_dat_o, s_dat_i);
      check("timeout",  timeout, mdl_timeout);
      check("timeout_nowd", timeout_z, 1'b0);
    end

    if (reset) begin
      mdl_owner   = 0;
      mdl_stalls  = 0;
      mdl_timeout = 1'b0;
      mdl_last_m1 = 1'b0;
      mdl_valid   = 1'b1;
    end else if (mdl_owner == 0) begin
      if ((m0_cyc && m0_stb) || (m1_cyc && m1_stb)) begin
        if (m0_cyc && m0_stb && m1_cyc && m1_stb) begin
`ifdef WB_ARB_ROUND_ROBIN_EN
          want_m1 = !mdl_last_m1;
`else
          want_m1 = 1'b1;
`endif
        end else begin
          want_m1 = m1_cyc && m1_stb;
        end
        mdl_owner   = want_m1 ? 2 : 1;
        mdl_last_m1 = want_m1;
        mdl_stalls  = 0;
      end
    end else begin
      own_cyc = (mdl_owner == 1) ? m0_cyc : m1_cyc;
      own_stb = (mdl_owner == 1) ? m0_stb : m1_stb;
      if (!own_cyc) begin
        mdl_owner = 0;
      end else if (s_ack) begin
        mdl_stalls = 0;
      end else if (own_stb && TO > 0) begin
        mdl_stalls++;
        if (mdl_stalls >= TO) begin
          mdl_owner   = 0;
          mdl_stalls  = 0;
          mdl_timeout = 1'b1;
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    m0_cyc = 0; m0_stb = 0; m0_we = 0; m0_adr = '0; m0_dat = '0; m0_sel = '0;
    m1_cyc = 0; m1_stb = 0; m1_we = 0; m1_adr = '0; m1_dat = '0; m1_sel = '0;
    s_ack  = 0; s_dat_i = '0;
  endtask

  logic [1:0] rr_exp;

  initial begin
    idle_inputs();
    reset = 1'b1;
    repeat (3) step();
    reset = 1'b0;

    // Single read from m0, slave acks two cycles after the request.
    m0_cyc = 1; m0_stb = 1; m0_we = 0; m0_adr = 32'h8000_0000; m0_sel = 4'hF;
    #1;
    check("rd_grant_c0", grant, 2'b00);
    check("rd_stb_c0",   s_stb, 1'b0);
    step(); #1;
    check("rd_grant_c1", grant, 2'b01);
    check("rd_stb_c1",   s_stb, 1'b1);
    check("rd_adr_c1",   s_adr, 32'h8000_0000);
    check("rd_ack_c1",   m0_ack, 1'b0);
    step();
    s_ack = 1; s_dat_i = 32'h0000_0013; m0_cyc = 0; m0_stb = 0;
    #1;
    check("rd_ack_c2",   m0_ack, 1'b1);
    check("rd_dat_c2",   m0_dat_o, 32'h0000_0013);
    check("rd_grant_c2", grant, 2'b01);
    step();
    s_ack = 0;
    #1;
    check("rd_grant_c3", grant, 2'b00);

    // Simultaneous requests: m1 write wins, m0 follows after one idle cycle.
    step();
    m0_cyc = 1; m0_stb = 1; m0_adr = 32'h8000_0004;
    m1_cyc = 1; m1_stb = 1; m1_we = 1; m1_adr = 32'h8040_0000;
    m1_dat = 32'hDEAD_BEEF; m1_sel = 4'hF;
    #1;
    check("pri_grant_c0", grant, 2'b00);
    step(); #1;
    check("pri_grant_c1", grant, 2'b10);
    check("pri_we_c1",    s_we, 1'b1);
    check("pri_adr_c1",   s_adr, 32'h8040_0000);
    check("pri_dat_c1",   s_dat_o, 32'hDEAD_BEEF);
    check("pri_sel_c1",   s_sel, 4'hF);
    s_ack = 1; m1_cyc = 0; m1_stb = 0; m1_we = 0;
    #1;
    check("pri_m1ack_c1", m1_ack, 1'b1);
    check("pri_m0ack_c1", m0_ack, 1'b0);
    step();
    s_ack = 0;
    #1;
    check("pri_gap_c2",   grant, 2'b00);
    check("pri_m0ack_c2", m0_ack, 1'b0);
    step(); #1;
    check("pri_grant_c3", grant, 2'b01);
    check("pri_adr_c3",   s_adr, 32'h8000_0004);
    s_ack = 1; m0_cyc = 0; m0_stb = 0;
    #1;
    check("pri_m0ack_c3", m0_ack, 1'b1);
    step();
    s_ack = 0;

    // Four back-to-back simultaneous requests from a fresh reset.
    reset = 1'b1;
    step(); step();
    reset = 1'b0;
    for (int r = 0; r < 4; r++) begin
      m0_cyc = 1; m0_stb = 1; m1_cyc = 1; m1_stb = 1;
      step(); #1;
`ifdef WB_ARB_ROUND_ROBIN_EN
      rr_exp = (r % 2 == 0) ? 2'b10 : 2'b01;
`else
      rr_exp = 2'b10;
`endif
      check($sformatf("arb_round%0d", r), grant, rr_exp);
      s_ack = 1; m0_cyc = 0; m0_stb = 0; m1_cyc = 0; m1_stb = 0;
      step();
      s_ack = 0;
    end

    // Watchdog: slave never acks, abort after TO stalled cycles.
    m0_cyc = 1; m0_stb = 1; m0_adr = 32'h8000_0100;
    step(); #1;
    check("wd_grant_c1", grant, 2'b01);
    repeat (3) step();
    #1;
    check("wd_grant_c4",   grant, 2'b01);
    check("wd_timeout_c4", timeout, 1'b0);
    step(); #1;
    check("wd_grant_c5",   grant, 2'b00);
    check("wd_timeout_c5", timeout, 1'b1);
    check("wd_ack_c5",     m0_ack, 1'b0);
    step(); #1;
    check("wd_regrant_c6", grant, 2'b01);
    m0_cyc = 0; m0_stb = 0;
    step(); #1;
    check("wd_sticky", timeout, 1'b1);

    // Reset in the middle of an m0 transfer.
    m0_cyc = 1; m0_stb = 1;
    step(); #1;
    check("rst_grant_c1", grant, 2'b01);
    step();
    reset = 1; s_ack = 1;
    #1;
    check("rst_cyc_c2", s_cyc, 1'b0);
    check("rst_ack_c2", m0_ack, 1'b0);
    step(); #1;
    check("rst_grant_c3",   grant, 2'b00);
    check("rst_timeout_c3", timeout, 1'b0);
    reset = 0; s_ack = 0;
    #1;
    check("rst_cyc_c3", s_cyc, 1'b0);
    step(); #1;
    check("rst_first_arb", grant, 2'b01);
    m0_cyc = 0; m0_stb = 0;
    step();

    // Randomized traffic with occasional resets.
    for (int i = 0; i < 3000; i++) begin
      step();
      reset = ($urandom_range(99) == 0);
      if (m0_cyc) m0_cyc = ($urandom_range(3) != 0);
      else        m0_cyc = ($urandom_range(2) == 0);
      if (m1_cyc) m1_cyc = ($urandom_range(3) != 0);
      else        m1_cyc = ($urandom_range(2) == 0);
      m0_stb  = m0_cyc && ($urandom_range(4) != 0);
      m1_stb  = m1_cyc && ($urandom_range(4) != 0);
      m0_we   = $urandom_range(1);
      m1_we   = $urandom_range(1);
      m0_adr  = $urandom;
      m1_adr  = $urandom;
      m0_dat  = $urandom;
      m1_dat  = $urandom;
      m0_sel  = SW'($urandom);
      m1_sel  = SW'($urandom);
      s_ack   = ($urandom_range(3) == 0);
      s_dat_i = $urandom;
    end

    reset = 0;
    idle_inputs();
    repeat (3) step();
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/wb_dual_master_arbiter.md
WB_DUAL_MASTER_ARBITER -- requirements
Module: wb_dual_master_arbiter

Interface
REQ-001 Parameter ADDR_WIDTH, default 32: Wishbone address width.
REQ-002 Parameter DATA_WIDTH, default 32: Wishbone data width; select width is DATA_WIDTH/8.
REQ-003 Parameter TIMEOUT, default 255: maximum wait cycles for slave ack; 0 disables the watchdog.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 m0_wb_cyc_i, m0_wb_stb_i, m0_wb_we_i  input  1 each  master 0 (instruction fetch) bus controls.
REQ-007 m0_wb_adr_i  input  ADDR_WIDTH; m0_wb_dat_i  input  DATA_WIDTH; m0_wb_sel_i  input  DATA_WIDTH/8  master 0 request payload.
REQ-008 m0_wb_ack_o  output  1; m0_wb_dat_o  output  DATA_WIDTH  master 0 response.
REQ-009 m1_* ports identical to REQ-006..008: master 1 (data memory) port.
REQ-010 s_wb_cyc_o, s_wb_stb_o, s_wb_we_o  output  1 each; s_wb_adr_o  output  ADDR_WIDTH; s_wb_dat_o  output  DATA_WIDTH; s_wb_sel_o  output  DATA_WIDTH/8  shared slave request.
REQ-011 s_wb_ack_i  input  1; s_wb_dat_i  input  DATA_WIDTH  shared slave response.
REQ-012 grant_o  output  2  one-hot current owner ({m1,m0}); 00 when idle.
REQ-013 timeout_o  output  1  sticky flag: a watchdog expiry has occurred.

Function
REQ-014 FSM states IDLE, GNT_M0, GNT_M1; state and grant are registers.
REQ-015 In IDLE, any master asserting cyc&stb wins at the next edge; slave strobe appears one cycle after request (arbitration latency 1 cycle).
REQ-016 In IDLE with both requesting, priority per Configuration; without macro, m1 (data) wins.
REQ-017 In GNT_mX, slave cyc/stb/we/adr/dat/sel SHALL be combinationally the owner's inputs; in IDLE, s_wb_cyc_o=s_wb_stb_o=0, other slave outputs 0.
REQ-018 s_wb_ack_i SHALL route only to the owner's ack; non-owner ack stays 0; s_wb_dat_i fans out to both m*_wb_dat_o unconditionally.
REQ-019 Owner keeps grant while its cyc is high (burst lock), across multiple acks.
REQ-020 Owner dropping cyc returns FSM to IDLE at that edge; a waiting master is granted no earlier than the following edge (one idle cycle between owners).
REQ-021 Non-owner request is held off (no ack) for any duration; its inputs are ignored.
REQ-022 Watchdog counter clears on grant and on every ack; increments each owned cycle with stb high and no ack.
REQ-023 Counter reaching TIMEOUT: FSM forced to IDLE, timeout_o set, no ack issued; re-arbitration proceeds normally next cycle.
REQ-024 Counter width SHALL hold TIMEOUT without wrap; TIMEOUT=0: counter never advances, timeout_o never set.
REQ-025 Ack coincident with owner dropping cyc: ack routed to owner, then IDLE.

Reset
REQ-026 reset high at any edge, including mid-transfer: FSM to IDLE, grant_o=00, counter=0, timeout_o=0, last-winner=m0; all slave request outputs and acks 0 the same cycle reset is sampled and thereafter until reset deasserts.
REQ-027 First arbitration occurs on the first edge after reset deasserts.

Configuration
REQ-028 Macro WB_ARB_ROUND_ROBIN_EN defined: simultaneous requests in IDLE granted to the master that did not win last; last-winner register updates on each grant.
REQ-029 Macro undefined: fixed priority, m1 always wins simultaneous requests; last-winner register absent.

Verification
REQ-030 After reset, m0 read adr 0x8000_0000, slave acks cycle 2 with 0x0000_0013 -> s_wb_stb_o high 1 cycle after request, m0_wb_ack_o with dat 0x0000_0013, grant_o=01 then 00.
REQ-031 m0 and m1 request same cycle (m1 write adr 0x8040_0000 dat 0xDEAD_BEEF sel 0xF) -> m1 granted (grant_o=10), slave sees we=1 and that payload; m0 granted after one idle cycle.
REQ-032 With WB_ARB_ROUND_ROBIN_EN, four back-to-back simultaneous requests -> grants alternate m1,m0,m1,m0.
REQ-033 m1 owner, slave acks in same cycle m0 asserts cyc -> m0_wb_ack_o stays 0 throughout m1 ownership.
REQ-034 TIMEOUT=4, slave never acks -> FSM returns IDLE after 4 stalled cycles, timeout_o=1 and stays 1 until reset, no master ack.
REQ-035 reset asserted during GNT_M0 before ack -> next cycle grant_o=00, s_wb_cyc_o=0, timeout_o=0.
